// File: rtl/dm_pkg.sv
// Shared types, constants and the load extraction helper for the data-memory unit.
package dm_pkg;

    localparam int unsigned store_type_size = 2;
    localparam int unsigned load_type_size  = 2;

    localparam logic [1:0] TYPE_WORD    = 2'd0;
    localparam logic [1:0] TYPE_HALF    = 2'd1;
    localparam logic [1:0] TYPE_BYTE    = 2'd2;
    localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_TYPE     = 2'd3;

    typedef enum logic {StClear, StIdle} dm_state_t;

    function automatic logic [31:0] dm_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] ltype, input logic sign);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] res;
        h = off[1] ? word[31:16] : word[15:0];
        b = 8'(word >> {off, 3'b000});
        case (ltype)
            TYPE_WORD: res = word;
            TYPE_HALF: res = {{16{sign & h[15]}}, h};
            TYPE_BYTE: res = {{24{sign & b[7]}}, b};
            default:   res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response bus between the EX/MEM register and the data-memory unit.
interface dm_if;
    import dm_pkg::*;

    logic                       req;
    logic                       ready;
    logic                       mem_write;
    logic [store_type_size-1:0] store_type;
    logic [load_type_size-1:0]  load_type;
    logic                       sign_read;
    logic [31:0]                addr;
    logic [31:0]                wd;
    logic                       rvalid;
    logic [31:0]                rd;
    logic [1:0]                 err_code;

    modport master (
        output req, mem_write, store_type, load_type, sign_read, addr, wd,
        input  ready, rvalid, rd, err_code
    );

    modport slave (
        input  req, mem_write, store_type, load_type, sign_read, addr, wd,
        output ready, rvalid, rd, err_code
    );

endinterface

// File: rtl/dm_ram.sv
// Single-port byte-enable word RAM, write-first, shaped for block-RAM inference.
module dm_ram #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    r_rdata[8*i +: 8]       <= i_wdata[8*i +: 8];
                end else begin
                    r_rdata[8*i +: 8]       <= r_mem[i_addr][8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_unit.sv
// MEM-stage data memory: lane decode, error checks, post-reset clear and a
// pipelined load path with optional output register.
module dm_unit
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 2048,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input logic i_clk,
    input logic i_rst,
    dm_if.slave io_bus
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    dm_state_t     r_state;
    logic [AW-1:0] r_cnt;

    logic          w_ready;
    logic          w_acc;
    logic [1:0]    w_type;
    logic [31:0]   w_off;
    logic [1:0]    w_err;
    logic [3:0]    w_lanes;
    logic          w_ram_en;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;

    logic          r_v1;
    logic          r_load1;
    logic [1:0]    r_off1;
    logic [1:0]    r_ltype1;
    logic          r_sign1;
    logic [1:0]    r_err1;
    logic [31:0]   w_rd1;
    logic [1:0]    w_err1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            r_cnt   <= '0;
        end else if (r_state == StClear) begin
            if (r_cnt == AW'(DEPTH_WORDS - 1)) r_state <= StIdle;
            r_cnt <= r_cnt + AW'(1);
        end
    end

    assign w_ready      = (r_state == StIdle);
    assign io_bus.ready = w_ready;
    assign w_acc        = io_bus.req && w_ready;
    assign w_type       = io_bus.mem_write ? io_bus.store_type : io_bus.load_type;
    assign w_off        = io_bus.addr - BASE_ADDR;

    always_comb begin
        w_err = ERR_NONE;
        if (w_type == TYPE_ILLEGAL) begin
            w_err = ERR_TYPE;
        end else if (io_bus.addr < BASE_ADDR || {1'b0, io_bus.addr} >= LIMIT) begin
            w_err = ERR_RANGE;
        end else if ((w_type == TYPE_HALF && io_bus.addr[0]) ||
                     (w_type == TYPE_WORD && io_bus.addr[1:0] != 2'b00)) begin
            w_err = ERR_MISALIGN;
        end
    end

    always_comb begin
        w_lanes = 4'b0000;
        case (io_bus.store_type)
            TYPE_WORD: w_lanes = 4'b1111;
            TYPE_HALF: w_lanes = io_bus.addr[1] ? 4'b1100 : 4'b0011;
            TYPE_BYTE: w_lanes = 4'b0001 << io_bus.addr[1:0];
            default:   w_lanes = 4'b0000;
        endcase
    end

    // The clear sweep owns the RAM port until the unit becomes ready.
    always_comb begin
        if (r_state == StClear) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 4'b1111;
            w_ram_addr  = r_cnt;
            w_ram_wdata = 32'h0;
        end else begin
            w_ram_en    = w_acc;
            w_ram_we    = (w_acc && io_bus.mem_write && w_err == ERR_NONE) ? w_lanes : 4'b0000;
            w_ram_addr  = AW'(w_off >> 2);
            w_ram_wdata = io_bus.wd << {io_bus.addr[1:0], 3'b000};
        end
    end

    dm_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_load1  <= 1'b0;
            r_off1   <= 2'b00;
            r_ltype1 <= TYPE_WORD;
            r_sign1  <= 1'b0;
            r_err1   <= ERR_NONE;
        end else begin
            r_v1     <= w_acc;
            r_load1  <= ~io_bus.mem_write;
            r_off1   <= io_bus.addr[1:0];
            r_ltype1 <= io_bus.load_type;
            r_sign1  <= io_bus.sign_read;
            r_err1   <= w_err;
        end
    end

    // Stores and erroring accesses always return zero data.
    assign w_rd1  = (r_v1 && r_load1 && r_err1 == ERR_NONE)
                  ? dm_extract(w_ram_rdata, r_off1, r_ltype1, r_sign1) : 32'h0;
    assign w_err1 = r_v1 ? r_err1 : ERR_NONE;

    if (OUT_REG != 0) begin : g_out_reg
        logic        r_v2;
        logic [31:0] r_rd2;
        logic [1:0]  r_err2;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_v2   <= 1'b0;
                r_rd2  <= 32'h0;
                r_err2 <= ERR_NONE;
            end else begin
                r_v2   <= r_v1;
                r_rd2  <= w_rd1;
                r_err2 <= w_err1;
            end
        end

        assign io_bus.rvalid   = r_v2;
        assign io_bus.rd       = r_rd2;
        assign io_bus.err_code = r_err2;
    end else begin : g_no_out_reg
        assign io_bus.rvalid   = r_v1;
        assign io_bus.rd       = w_rd1;
        assign io_bus.err_code = w_err1;
    end

endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench: two DUTs (OUT_REG 0 and 1) share stimulus; monitors check data,
// error code and response cycle against queued expectations.
module tb_dm_unit;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    dm_if bus0 ();
    dm_if bus1 ();

    assign bus1.req        = bus0.req;
    assign bus1.mem_write  = bus0.mem_write;
    assign bus1.store_type = bus0.store_type;
    assign bus1.load_type  = bus0.load_type;
    assign bus1.sign_read  = bus0.sign_read;
    assign bus1.addr       = bus0.addr;
    assign bus1.wd         = bus0.wd;

    dm_unit #(
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (32'h0000_0000),
        .OUT_REG       (0),
        .CLEAR_ON_RESET(1)
    ) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus0.slave)
    );

    dm_unit #(
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (32'h0000_0000),
        .OUT_REG       (1),
        .CLEAR_ON_RESET(1)
    ) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic [31:0] rd, input logic [1:0] err);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid dut%0d: got rd %h err %0d expected no response",
                     d, rd, err);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("rd dut%0d", d), rd, e.rd);
            check($sformatf("err dut%0d", d), {30'b0, err}, {30'b0, e.err});
            check($sformatf("latency dut%0d", d), 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (bus0.rvalid) mon(0, bus0.rd, bus0.err_code);
        if (bus1.rvalid) mon(1, bus1.rd, bus1.err_code);
    end

    task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err,
                         input bit expect_resp);
        exp_t e;
        bus0.req        = 1'b1;
        bus0.mem_write  = we;
        bus0.store_type = typ;
        bus0.load_type  = typ;
        bus0.sign_read  = sgn;
        bus0.addr       = a;
        bus0.wd         = wd;
        if (expect_resp) begin
            e.rd  = exp_rd;
            e.err = exp_err;
            e.due = cyc + 1;
            q0.push_back(e);
            e.due = cyc + 2;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus0.req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, " ready"}, {30'b0, bus0.ready, bus1.ready}, 32'h0);
        check({tag, " rvalid"}, {30'b0, bus0.rvalid, bus1.rvalid}, 32'h0);
        check({tag, " rd0"}, bus0.rd, 32'h0);
        check({tag, " rd1"}, bus1.rd, 32'h0);
        check({tag, " err"}, {28'b0, bus0.err_code, bus1.err_code}, 32'h0);
    endtask

    // Counts not-ready negedges from release; bounded so a stuck FSM still terminates.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus0.ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        bus0.req = 1'b0;
        check({tag, " clear_cycles"}, 32'(n), 32'd16);
        check({tag, " ready1"}, {31'b0, bus1.ready}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Store held during reset and clear must be ignored.
        bus0.req        = 1'b1;
        bus0.mem_write  = 1'b1;
        bus0.store_type = TYPE_WORD;
        bus0.load_type  = TYPE_WORD;
        bus0.sign_read  = 1'b0;
        bus0.addr       = 32'h3C;
        bus0.wd         = 32'h0000_0055;
        rst             = 1'b1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear("first");
        @(posedge clk);
        #1;

        issue(0, TYPE_WORD, 0, 32'h3C, 32'h0, 32'h0000_0000, ERR_NONE, 1);

        issue(1, TYPE_WORD, 0, 32'h08, 32'h1122_3344, 32'h0, ERR_NONE, 1);
        issue(1, TYPE_BYTE, 0, 32'h0A, 32'h0000_00AB, 32'h0, ERR_NONE, 1);
        issue(0, TYPE_WORD, 0, 32'h08, 32'h0, 32'h11AB_3344, ERR_NONE, 1);
        issue(0, TYPE_BYTE, 1, 32'h0A, 32'h0, 32'hFFFF_FFAB, ERR_NONE, 1);
        issue(0, TYPE_HALF, 0, 32'h0A, 32'h0, 32'h0000_11AB, ERR_NONE, 1);

        issue(0, TYPE_HALF, 0, 32'h03, 32'h0, 32'h0, ERR_MISALIGN, 1);
        issue(1, TYPE_WORD, 0, 32'h40, 32'hCAFE_F00D, 32'h0, ERR_RANGE, 1);
        issue(0, TYPE_WORD, 0, 32'h00, 32'h0, 32'h0000_0000, ERR_NONE, 1);
        issue(1, TYPE_ILLEGAL, 0, 32'h41, 32'h0, 32'h0, ERR_TYPE, 1);
        issue(0, TYPE_ILLEGAL, 0, 32'h10, 32'h0, 32'h0, ERR_TYPE, 1);
        issue(0, TYPE_BYTE, 0, 32'h41, 32'h0, 32'h0, ERR_RANGE, 1);
        issue(0, TYPE_WORD, 0, 32'h06, 32'h0, 32'h0, ERR_MISALIGN, 1);
        issue(1, TYPE_HALF, 0, 32'h05, 32'h0000_7777, 32'h0, ERR_MISALIGN, 1);
        issue(0, TYPE_WORD, 0, 32'h08, 32'h0, 32'h11AB_3344, ERR_NONE, 1);

        issue(1, TYPE_WORD, 0, 32'h04, 32'hDEAD_BEEF, 32'h0, ERR_NONE, 1);
        issue(0, TYPE_WORD, 0, 32'h04, 32'h0, 32'hDEAD_BEEF, ERR_NONE, 1);
        issue(0, TYPE_HALF, 1, 32'h06, 32'h0, 32'hFFFF_DEAD, ERR_NONE, 1);
        issue(0, TYPE_HALF, 1, 32'h04, 32'h0, 32'hFFFF_BEEF, ERR_NONE, 1);
        issue(0, TYPE_BYTE, 0, 32'h07, 32'h0, 32'h0000_00DE, ERR_NONE, 1);
        issue(1, TYPE_HALF, 0, 32'h06, 32'hFFFF_1234, 32'h0, ERR_NONE, 1);
        issue(0, TYPE_WORD, 0, 32'h04, 32'h0, 32'h1234_BEEF, ERR_NONE, 1);
        issue(0, TYPE_BYTE, 1, 32'h05, 32'h0, 32'hFFFF_FFBE, ERR_NONE, 1);
        idle(3);

        // Load accepted, then reset before its response: must be dropped.
        issue(0, TYPE_WORD, 0, 32'h04, 32'h0, 32'h0, ERR_NONE, 0);
        rst = 1'b1;
        bus0.req = 1'b0;
        check_reset_outputs("midop");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear("restart");
        @(posedge clk);
        #1;

        issue(0, TYPE_WORD, 0, 32'h04, 32'h0, 32'h0000_0000, ERR_NONE, 1);
        issue(0, TYPE_WORD, 0, 32'h08, 32'h0, 32'h0000_0000, ERR_NONE, 1);
        issue(1, TYPE_BYTE, 0, 32'h3F, 32'h0000_0080, 32'h0, ERR_NONE, 1);
        issue(0, TYPE_WORD, 0, 32'h3C, 32'h0, 32'h8000_0000, ERR_NONE, 1);
        issue(0, TYPE_BYTE, 1, 32'h3F, 32'h0, 32'hFFFF_FF80, ERR_NONE, 1);
        idle(4);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
Parametrised data-memory unit for the pipelined MIPS core. It replaces the fixed 2K-word data memory and its separate byte-enable decoder and load selector with one block. The block provides:
- an inferred synchronous word RAM;
- sub-word store lane decode and sub-word load extraction with sign or zero extension;
- a valid/ready request handshake;
- range, alignment and type error reporting;
- a post-reset clear state machine.

It sits in the MEM stage and is driven directly by the EX/MEM pipeline register.

Parameters:
DEPTH_WORDS, 2048, number of 32-bit words; must be a power of two.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage, giving latency 2.
CLEAR_ON_RESET, 1, 1 means the FSM zeroes every word after reset; 0 means the block goes straight to IDLE.

Ports:
Clock  input  1  single clock; all logic is on its rising edge.
Reset  input  1  asynchronous, active-high reset.
Req  input  1  access request.
Ready  output  1  the block accepts Req this cycle.
MemWrite  input  1  1 = store, 0 = load.
StoreType  input  2  0 word, 1 half, 2 byte, 3 illegal.
LoadType  input  2  0 word, 1 half, 2 byte, 3 illegal.
SignRead  input  1  sign-extend a sub-word load (1) or zero-extend it (0).
Addr  input  32  byte address.
WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
RValid  output  1  one-cycle response pulse for each accepted request.
RD  output  32  extracted and extended load data; 0 for stores and errors.
ErrCode  output  2  0 ok, 1 misaligned, 2 out of range, 3 illegal type.

Behaviour:
- Reset is asynchronous. While Reset is high, and in the cycle it is released:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE;
  - clear counter = 0, Ready = 0 (in CLEAR);
  - RValid = 0, RD = 0, ErrCode = 0;
  - the pipeline valid bits are cleared, so in-flight responses are dropped.
- FSM states: CLEAR and IDLE.
  - CLEAR writes 0 to word cnt each cycle, cnt = 0 .. DEPTH_WORDS-1, then moves to IDLE. It takes exactly DEPTH_WORDS cycles.
  - Reset asserted mid-clear restarts at cnt = 0.
  - IDLE is permanent until the next Reset.
- Ready = (state == IDLE), decoded combinationally from the state register. Req while Ready = 0 is ignored and produces no response.
- Acceptance happens when Req && Ready. One access is accepted per cycle, fully pipelined, with no back-pressure.
- Word index = (Addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Error checks, in priority order (first match wins):
  1. illegal type (the type field selected by MemWrite equals 3) → ErrCode 3;
  2. Addr < BASE_ADDR or Addr ≥ BASE_ADDR + 4·DEPTH_WORDS → ErrCode 2;
  3. half with Addr[0] = 1, or word with Addr[1:0] ≠ 0 → ErrCode 1.
  An erroring access does not write memory and returns RD = 0.
- Store lane decode (lane i = bits 8i+7:8i):
  - word → 1111;
  - half → 0011 if Addr[1] = 0, 1100 if Addr[1] = 1;
  - byte → 0001 shifted left by Addr[1:0].
  - Write data = WD << {Addr[1:0], 3'b0}.
  - Only enabled lanes are written at the acceptance edge; the other bytes of the word keep their values.
- Load path:
  - The RAM read is synchronous, at the acceptance edge.
  - Addr[1:0], LoadType, SignRead and the error code are registered alongside the read.
  - Extraction is combinational on the registered word.
  - Half selects [15:0] if Addr[1] = 0, [31:16] if Addr[1] = 1.
  - Byte selects lane Addr[1:0].
  - Sign-extend if SignRead, else zero-extend.
- Latency:
  - RValid, RD and ErrCode are valid 1 + OUT_REG cycles after acceptance.
  - With OUT_REG = 1, extraction is done before the final register.
  - RValid is low when there is no response.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the post-store value.
- Store responses: RValid pulses with RD = 0 and the ErrCode of that store.

Decomposition:
- Shared package `dm_pkg`:
  - constants for the access types: TYPE_WORD = 0, TYPE_HALF = 1, TYPE_BYTE = 2;
  - constants for the error codes: ERR_NONE/MISALIGN/RANGE/TYPE;
  - widths `store_type_size` and `load_type_size` = 2.
- Sub-module `dm_ram`: a single-port, byte-enable, write-first RAM with parameter DEPTH_WORDS. It keeps the memory inferable as BRAM.
- The lane decode, extraction, error check, FSM and pipeline stay in dm_unit.

Test Plan:
1. Reset, CLEAR_ON_RESET = 1, DEPTH_WORDS = 16 → Ready is 0 for exactly 16 cycles after release, then 1. A word load at 0x3C returns 0x00000000.
2. Store word 0x11223344 @0x8, store byte WD = 0xAB @0xA, then load word @0x8 → 0x11AB3344. A load byte, SignRead = 1, @0xA → 0xFFFFFFAB. A load half, SignRead = 0, @0xA → 0x000011AB.
3. Load half @0x3 → ErrCode 1, RD 0. Store word @0x40 (DEPTH 16) → ErrCode 2, and memory is unchanged. StoreType 3 @0x41 → ErrCode 3, because type beats range.
4. Back-to-back store word 0xDEADBEEF @0x4 followed by load word @0x4 in the next cycle → RD 0xDEADBEEF. With OUT_REG = 1, RValid arrives 2 cycles after acceptance and responses stay in order for 4 consecutive requests.
5. Reset asserted at clear cycle 5 → the clear restarts and Ready rises 16 cycles after the second release. An in-flight load issued before a mid-operation reset produces no RValid.
